// File: rtl/key_event_arbiter_if.sv
// key_event_arbiter_if: request pulses, one-deep event slot handshake and status for key_event_arbiter
interface key_event_arbiter_if #(parameter int N_CH = 4, parameter int ID_W = 2);
  logic [N_CH-1:0] req_pulse, pending;
  logic [ID_W-1:0] evt_id;
  logic evt_valid, evt_ready, overflow, ovf_clr;
  modport master(output req_pulse, evt_ready, ovf_clr, input evt_valid, evt_id, pending, overflow);
  modport slave(input req_pulse, evt_ready, ovf_clr, output evt_valid, evt_id, pending, overflow);
endinterface

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: round-robin merge of edge pulses into a one-deep event slot.
// Define KEY_ARB_HOLDOFF_EN to drop re-pulses on a channel for HOLDOFF cycles after an accepted one.
module key_event_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2,
  parameter int HOLDOFF = 1000
) (
  input logic clk,
  input logic rst,
  key_event_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [ID_W-1:0] evt_id, last_id, pick, c;
  logic [N_CH-1:0] pending, acc, gnt_vec;
  logic overflow, loadable, grant;
  assign loadable = state == EMPTY || bus.evt_ready;
  assign grant = loadable && |pending;
  assign gnt_vec = grant ? N_CH'(1) << pick : '0;
  // descending scan so the nearest channel after last_id is written last and wins
  always_comb begin
    pick = last_id;
    c = '0;
    for (int k = N_CH; k >= 1; k--) begin
      c = ID_W'((int'(last_id) + k) % N_CH);
      if (pending[c]) pick = c;
    end
  end
`ifdef KEY_ARB_HOLDOFF_EN
  localparam int CW = HOLDOFF < 2 ? 1 : $clog2(HOLDOFF);
  logic [CW-1:0] cnt [N_CH];
  for (genvar i = 0; i < N_CH; i++) begin : g_ho
    assign acc[i] = bus.req_pulse[i] && cnt[i] == '0;
    always_ff @(posedge clk)
      if (rst) cnt[i] <= '0;
      else cnt[i] <= acc[i] ? CW'(HOLDOFF - 1) : cnt[i] - CW'(cnt[i] != '0);
  end
`else
  logic holdoff_unused;
  assign holdoff_unused = |HOLDOFF;
  assign acc = bus.req_pulse;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      evt_id <= '0;
      last_id <= ID_W'(N_CH - 1);
      pending <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~gnt_vec) | acc;
      overflow <= |(acc & pending & ~gnt_vec) || (overflow && !bus.ovf_clr);
      if (grant) begin
        state <= FULL;
        evt_id <= pick;
        last_id <= pick;
      end else if (loadable) state <= EMPTY;
    end
  end
  assign bus.evt_valid = state == FULL;
  assign bus.evt_id = evt_id;
  assign bus.pending = pending;
  assign bus.overflow = overflow;
endmodule
